// File: rtl/jtkiwi_vtimer_gen_pkg.sv
// Default geometry for the kiwi/bubl video timer, shared by the timer and line-buffer logic.
package jtkiwi_vtimer_gen_pkg;
  localparam int         DEF_HW         = 9;
  localparam int         DEF_VW         = 9;
  localparam logic [8:0] DEF_HCNT_START = 9'd0;
  localparam logic [8:0] DEF_HCNT_END   = 9'd383;
  localparam logic [8:0] DEF_HB_START   = 9'd255;
  localparam logic [8:0] DEF_HB_END     = 9'd383;
  localparam logic [8:0] DEF_HS_START   = 9'd297;
  localparam logic [5:0] DEF_HS_LEN     = 6'd32;
  localparam logic [8:0] DEF_V_START    = 9'd8;
  localparam logic [8:0] DEF_VCNT_END   = 9'd271;
  localparam logic [8:0] DEF_VB_START   = 9'd239;
  localparam logic [8:0] DEF_VB_END     = 9'd15;
  localparam logic [8:0] DEF_VS_START   = 9'd254;
  localparam logic [2:0] DEF_VS_LEN     = 3'd3;
  localparam int         DEF_AHEAD      = 1;
endpackage

// File: rtl/jtkiwi_vtimer_wrap.sv
// Combinational modular add: base+k folded back into the counter range [start, fin].
// k is signed and must be smaller in magnitude than the range length.
module jtkiwi_vtimer_wrap import jtkiwi_vtimer_gen_pkg::*; #(
  parameter int W = DEF_HW
) (
  input  logic [W-1:0] base,
  input  logic [W:0]   k,
  input  logic [W-1:0] start,
  input  logic [W-1:0] fin,
  output logic [W-1:0] sum
);
  logic signed [W+1:0] lo, hi, span, raw;

  always_comb begin
    lo   = $signed({2'b00, start});
    hi   = $signed({2'b00, fin});
    span = hi - lo + (W+2)'(1);
    raw  = $signed({2'b00, base}) + $signed({k[W], k});
    if (raw > hi)      sum = W'(raw - span);
    else if (raw < lo) sum = W'(raw + span);
    else               sum = W'(raw);
  end
endmodule

// File: rtl/jtkiwi_vtimer_gen.sv
// Parametrised H/V video timing generator with N-line render look-ahead.
// Optional sync-position adjust (hadj/vadj ports) enabled by JTKIWI_VTIMER_ADJ_EN.
module jtkiwi_vtimer_gen import jtkiwi_vtimer_gen_pkg::*; #(
  parameter int            HW         = DEF_HW,
  parameter int            VW         = DEF_VW,
  parameter logic [HW-1:0] HCNT_START = DEF_HCNT_START,
  parameter logic [HW-1:0] HCNT_END   = DEF_HCNT_END,
  parameter logic [HW-1:0] HB_START   = DEF_HB_START,
  parameter logic [HW-1:0] HB_END     = DEF_HB_END,
  parameter logic [HW-1:0] HS_START   = DEF_HS_START,
  parameter logic [5:0]    HS_LEN     = DEF_HS_LEN,
  parameter logic [VW-1:0] V_START    = DEF_V_START,
  parameter logic [VW-1:0] VCNT_END   = DEF_VCNT_END,
  parameter logic [VW-1:0] VB_START   = DEF_VB_START,
  parameter logic [VW-1:0] VB_END     = DEF_VB_END,
  parameter logic [VW-1:0] VS_START   = DEF_VS_START,
  parameter logic [2:0]    VS_LEN     = DEF_VS_LEN,
  parameter int            AHEAD      = DEF_AHEAD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  output logic [HW-1:0] hdump,
  output logic [VW-1:0] vdump,
  output logic [VW-1:0] vrender,
  output logic [VW-1:0] vrender1,
  output logic          Hinit,
  output logic          Vinit,
  output logic          LHBL,
  output logic          LVBL,
  output logic          HS,
  output logic          VS
`ifdef JTKIWI_VTIMER_ADJ_EN
  ,
  input  logic [3:0]    hadj,
  input  logic [3:0]    vadj
`endif
);
  logic [HW-1:0] hnext;
  logic [VW-1:0] vnext;
  logic [5:0]    hs_cnt;
  logic [2:0]    vs_cnt;
  logic [HW-1:0] hs_start;
  logic [VW-1:0] vs_start;

  assign Hinit = hdump == HCNT_END;
  assign Vinit = Hinit && vdump == VCNT_END;
  assign hnext = Hinit ? HCNT_START : hdump + HW'(1);
  assign vnext = !Hinit ? vdump : (vdump == VCNT_END ? V_START : vdump + VW'(1));

  jtkiwi_vtimer_wrap #(.W(VW)) u_vrender (
    .base(vdump), .k((VW+1)'(AHEAD)), .start(V_START), .fin(VCNT_END), .sum(vrender)
  );
  jtkiwi_vtimer_wrap #(.W(VW)) u_vrender1 (
    .base(vdump), .k((VW+1)'(AHEAD + 1)), .start(V_START), .fin(VCNT_END), .sum(vrender1)
  );

`ifdef JTKIWI_VTIMER_ADJ_EN
  logic [HW-1:0] hs_adj;
  logic [VW-1:0] vs_adj;

  jtkiwi_vtimer_wrap #(.W(HW)) u_hadj (
    .base(HS_START), .k({{(HW-3){hadj[3]}}, hadj}), .start(HCNT_START), .fin(HCNT_END), .sum(hs_adj)
  );
  jtkiwi_vtimer_wrap #(.W(VW)) u_vadj (
    .base(VS_START), .k({{(VW-3){vadj[3]}}, vadj}), .start(V_START), .fin(VCNT_END), .sum(vs_adj)
  );

  // Offsets only move at the frame boundary so a sync pulse is never cut short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_start <= HS_START;
      vs_start <= VS_START;
    end else if (pxl_cen && Vinit) begin
      hs_start <= hs_adj;
      vs_start <= vs_adj;
    end
  end
`else
  assign hs_start = HS_START;
  assign vs_start = VS_START;
`endif

  // Flags are decoded against the next count so edges line up with the hdump value they name.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdump  <= HCNT_START;
      vdump  <= V_START;
      LHBL   <= 1'b0;
      LVBL   <= 1'b0;
      HS     <= 1'b0;
      VS     <= 1'b0;
      hs_cnt <= 6'd0;
      vs_cnt <= 3'd0;
    end else if (pxl_cen) begin
      hdump <= hnext;
      vdump <= vnext;
      if (hnext == HB_START)    LHBL <= 1'b0;
      else if (hnext == HB_END) LHBL <= 1'b1;
      if (hnext == HB_START) begin
        if (vnext == VB_START)    LVBL <= 1'b0;
        else if (vnext == VB_END) LVBL <= 1'b1;
      end
      if (hnext == hs_start && HS_LEN != 6'd0) begin
        HS     <= 1'b1;
        hs_cnt <= HS_LEN - 6'd1;
      end else if (hs_cnt != 6'd0) begin
        hs_cnt <= hs_cnt - 6'd1;
      end else begin
        HS <= 1'b0;
      end
      if (hnext == hs_start) begin
        if (vnext == vs_start && VS_LEN != 3'd0) begin
          VS     <= 1'b1;
          vs_cnt <= VS_LEN - 3'd1;
        end else if (vs_cnt != 3'd0) begin
          vs_cnt <= vs_cnt - 3'd1;
        end else begin
          VS <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_jtkiwi_vtimer_gen.sv
// Directed bench: default-geometry timer for line timing, compact-geometry timer (AHEAD=3) for frame timing.
module tb_jtkiwi_vtimer_gen;
  logic clk, rst, cen;
  int errors, checks;

  logic [8:0] d_hdump, d_vdump, d_vrender, d_vrender1;
  logic       d_Hinit, d_Vinit, d_LHBL, d_LVBL, d_HS, d_VS;
  logic [8:0] s_hdump, s_vdump, s_vrender, s_vrender1;
  logic       s_Hinit, s_Vinit, s_LHBL, s_LVBL, s_HS, s_VS;
`ifdef JTKIWI_VTIMER_ADJ_EN
  logic [3:0] d_hadj, d_vadj, s_hadj, s_vadj;
`endif

  jtkiwi_vtimer_gen d (
    .clk(clk), .rst(rst), .pxl_cen(cen),
    .hdump(d_hdump), .vdump(d_vdump), .vrender(d_vrender), .vrender1(d_vrender1),
    .Hinit(d_Hinit), .Vinit(d_Vinit), .LHBL(d_LHBL), .LVBL(d_LVBL), .HS(d_HS), .VS(d_VS)
`ifdef JTKIWI_VTIMER_ADJ_EN
    , .hadj(d_hadj), .vadj(d_vadj)
`endif
  );

  jtkiwi_vtimer_gen #(
    .HCNT_START(9'd0), .HCNT_END(9'd47), .HB_START(9'd31), .HB_END(9'd47),
    .HS_START(9'd37), .HS_LEN(6'd4), .V_START(9'd8), .VCNT_END(9'd40),
    .VB_START(9'd30), .VB_END(9'd12), .VS_START(9'd33), .VS_LEN(3'd3), .AHEAD(3)
  ) s (
    .clk(clk), .rst(rst), .pxl_cen(cen),
    .hdump(s_hdump), .vdump(s_vdump), .vrender(s_vrender), .vrender1(s_vrender1),
    .Hinit(s_Hinit), .Vinit(s_Vinit), .LHBL(s_LHBL), .LVBL(s_LVBL), .HS(s_HS), .VS(s_VS)
`ifdef JTKIWI_VTIMER_ADJ_EN
    , .hadj(s_hadj), .vadj(s_vadj)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cen = 1'b0;
    forever begin
      @(negedge clk);
      cen = ~cen;
    end
  end

  task automatic tick();
    do @(posedge clk); while (cen !== 1'b1);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks += 7;
    if (d_hdump !== 9'd0)    begin errors++; $display("FAIL reset_hdump got=%0d want=0", d_hdump); end
    if (d_vdump !== 9'd8)    begin errors++; $display("FAIL reset_vdump got=%0d want=8", d_vdump); end
    if (d_vrender !== 9'd9)  begin errors++; $display("FAIL reset_vrender got=%0d want=9", d_vrender); end
    if (d_vrender1 !== 9'd10) begin errors++; $display("FAIL reset_vrender1 got=%0d want=10", d_vrender1); end
    if ({d_LHBL, d_LVBL, d_HS, d_VS, d_Hinit, d_Vinit} !== 6'b0)
      begin errors++; $display("FAIL reset_flags got=%b want=000000", {d_LHBL, d_LVBL, d_HS, d_VS, d_Hinit, d_Vinit}); end
    if (s_vrender !== 9'd11) begin errors++; $display("FAIL reset_s_vrender got=%0d want=11", s_vrender); end
    if (s_vrender1 !== 9'd12) begin errors++; $display("FAIL reset_s_vrender1 got=%0d want=12", s_vrender1); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_hline();
    int herr, hin, vin, lf, lr, hr, hw;
    logic pl, ph, hs_done;
    herr = 0; hin = 0; vin = 0; lf = -1; lr = -1; hr = -1; hw = 0;
    hs_done = 1'b0; pl = d_LHBL; ph = d_HS;
    for (int t = 1; t <= 1152; t++) begin
      tick();
      if (d_hdump !== 9'(t % 384)) herr++;
      if (d_Hinit) hin++;
      if (d_Vinit) vin++;
      if (pl && !d_LHBL && lf < 0) lf = int'(d_hdump);
      if (!pl && d_LHBL && lr < 0) lr = int'(d_hdump);
      if (!ph && d_HS && hr < 0) hr = int'(d_hdump);
      if (d_HS && !hs_done) hw++;
      if (ph && !d_HS) hs_done = 1'b1;
      pl = d_LHBL; ph = d_HS;
    end
    checks += 10;
    if (herr != 0)   begin errors++; $display("FAIL hline_count got=%0d bad ticks want=0", herr); end
    if (hin != 3)    begin errors++; $display("FAIL hline_hinit got=%0d want=3", hin); end
    if (vin != 0)    begin errors++; $display("FAIL hline_vinit got=%0d want=0", vin); end
    if (lf != 255)   begin errors++; $display("FAIL hline_lhbl_fall got=%0d want=255", lf); end
    if (lr != 383)   begin errors++; $display("FAIL hline_lhbl_rise got=%0d want=383", lr); end
    if (hr != 297)   begin errors++; $display("FAIL hline_hs_rise got=%0d want=297", hr); end
    if (hw != 32)    begin errors++; $display("FAIL hline_hs_width got=%0d want=32", hw); end
    if (d_vdump !== 9'd11)    begin errors++; $display("FAIL hline_vdump got=%0d want=11", d_vdump); end
    if (d_vrender !== 9'd12)  begin errors++; $display("FAIL hline_vrender got=%0d want=12", d_vrender); end
    if (d_vrender1 !== 9'd13) begin errors++; $display("FAIL hline_vrender1 got=%0d want=13", d_vrender1); end
  endtask

  task automatic test_frame();
    int vin, vin_t;
    logic [8:0] vr39, vr1_39, vr40, vr1_40;
    logic [17:0] lv_rise, lv_fall, vs_rise, vs_fall;
    logic plv, pvs;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    vin = 0; vin_t = -1; vr39 = '0; vr1_39 = '0; vr40 = '0; vr1_40 = '0;
    lv_rise = '1; lv_fall = '1; vs_rise = '1; vs_fall = '1;
    plv = s_LVBL; pvs = s_VS;
    for (int t = 1; t <= 1584; t++) begin
      tick();
      if (s_Vinit) begin vin++; vin_t = t; end
      if (s_hdump == 9'd0 && s_vdump == 9'd39) begin vr39 = s_vrender; vr1_39 = s_vrender1; end
      if (s_hdump == 9'd0 && s_vdump == 9'd40) begin vr40 = s_vrender; vr1_40 = s_vrender1; end
      if (!plv && s_LVBL && lv_rise == '1) lv_rise = {s_hdump, s_vdump};
      if (plv && !s_LVBL && lv_fall == '1) lv_fall = {s_hdump, s_vdump};
      if (!pvs && s_VS && vs_rise == '1) vs_rise = {s_hdump, s_vdump};
      if (pvs && !s_VS && vs_fall == '1) vs_fall = {s_hdump, s_vdump};
      plv = s_LVBL; pvs = s_VS;
    end
    checks += 14;
    if (vin != 1)       begin errors++; $display("FAIL frame_vinit_count got=%0d want=1", vin); end
    if (vin_t != 1583)  begin errors++; $display("FAIL frame_vinit_tick got=%0d want=1583", vin_t); end
    if (vr39 !== 9'd9)  begin errors++; $display("FAIL frame_vrender_v39 got=%0d want=9", vr39); end
    if (vr1_39 !== 9'd10) begin errors++; $display("FAIL frame_vrender1_v39 got=%0d want=10", vr1_39); end
    if (vr40 !== 9'd10) begin errors++; $display("FAIL frame_vrender_v40 got=%0d want=10", vr40); end
    if (vr1_40 !== 9'd11) begin errors++; $display("FAIL frame_vrender1_v40 got=%0d want=11", vr1_40); end
    if (s_hdump !== 9'd0) begin errors++; $display("FAIL frame_wrap_hdump got=%0d want=0", s_hdump); end
    if (s_vdump !== 9'd8) begin errors++; $display("FAIL frame_wrap_vdump got=%0d want=8", s_vdump); end
    if (s_vrender !== 9'd11)  begin errors++; $display("FAIL frame_wrap_vrender got=%0d want=11", s_vrender); end
    if (s_vrender1 !== 9'd12) begin errors++; $display("FAIL frame_wrap_vrender1 got=%0d want=12", s_vrender1); end
    if (lv_rise !== {9'd31, 9'd12}) begin errors++; $display("FAIL frame_lvbl_rise got=h%0d/v%0d want=h31/v12", lv_rise[17:9], lv_rise[8:0]); end
    if (lv_fall !== {9'd31, 9'd30}) begin errors++; $display("FAIL frame_lvbl_fall got=h%0d/v%0d want=h31/v30", lv_fall[17:9], lv_fall[8:0]); end
    if (vs_rise !== {9'd37, 9'd33}) begin errors++; $display("FAIL frame_vs_rise got=h%0d/v%0d want=h37/v33", vs_rise[17:9], vs_rise[8:0]); end
    if (vs_fall !== {9'd37, 9'd36}) begin errors++; $display("FAIL frame_vs_fall got=h%0d/v%0d want=h37/v36", vs_fall[17:9], vs_fall[8:0]); end
  endtask

  task automatic test_midline_reset();
    int n;
    n = 0;
    while (d_hdump !== 9'd100 && n < 1000) begin tick(); n++; end
    checks += 3;
    if (d_hdump !== 9'd100) begin errors++; $display("FAIL midrst_reach got=%0d want=100", d_hdump); end
    if (d_vdump !== 9'd12)  begin errors++; $display("FAIL midrst_pre_vdump got=%0d want=12", d_vdump); end
    if (d_LHBL !== 1'b1)    begin errors++; $display("FAIL midrst_pre_lhbl got=%b want=1", d_LHBL); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks += 4;
    if (d_hdump !== 9'd0) begin errors++; $display("FAIL midrst_hdump got=%0d want=0", d_hdump); end
    if (d_vdump !== 9'd8) begin errors++; $display("FAIL midrst_vdump got=%0d want=8", d_vdump); end
    if ({d_LHBL, d_LVBL, d_HS, d_VS, d_Hinit, d_Vinit} !== 6'b0)
      begin errors++; $display("FAIL midrst_flags got=%b want=000000", {d_LHBL, d_LVBL, d_HS, d_VS, d_Hinit, d_Vinit}); end
    if (d_vrender !== 9'd9) begin errors++; $display("FAIL midrst_vrender got=%0d want=9", d_vrender); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks += 2;
    if (d_hdump !== 9'd5) begin errors++; $display("FAIL midrst_restart_h got=%0d want=5", d_hdump); end
    if (d_vdump !== 9'd8) begin errors++; $display("FAIL midrst_restart_v got=%0d want=8", d_vdump); end
  endtask

`ifdef JTKIWI_VTIMER_ADJ_EN
  task automatic test_adj();
    int before, after;
    logic seen_v, ph;
    before = -1; after = -1; seen_v = 1'b0; ph = s_HS;
    s_hadj = 4'hE;
    for (int t = 0; t < 2 * 1584 && after < 0; t++) begin
      tick();
      if (!ph && s_HS) begin
        if (seen_v) after = int'(s_hdump);
        else        before = int'(s_hdump);
      end
      if (s_Vinit) seen_v = 1'b1;
      ph = s_HS;
    end
    checks += 2;
    if (before != 37) begin errors++; $display("FAIL adj_hs_before got=%0d want=37", before); end
    if (after != 35)  begin errors++; $display("FAIL adj_hs_after got=%0d want=35", after); end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
`ifdef JTKIWI_VTIMER_ADJ_EN
    d_hadj = 4'h0; d_vadj = 4'h0; s_hadj = 4'h0; s_vadj = 4'h0;
`endif
    test_reset();
    test_hline();
    test_frame();
    test_midline_reset();
`ifdef JTKIWI_VTIMER_ADJ_EN
    test_adj();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
